// File: rtl/mem_stream_reader.sv
// mem_stream_reader
//   Read-side initiator for the image memory. A start command reads the run
//   [base_addr, base_addr+length) and presents the words in ascending address
//   order as a valid/ready stream. A small FIFO absorbs the memory's fixed
//   read latency. A credit check makes sure every issued read has a FIFO slot
//   reserved, so the FIFO cannot overflow.
//
// Stream handshake: a word transfers on the rising edge where
//   out_valid && out_ready. out_valid never drops, and out_data/out_last hold
//   steady, while a word waits for out_ready.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, base_addr,     transfer request (sampled only in IDLE)
//   length
//   busy, done, err       status: running / completion pulse / reject pulse
//   mem_address,          memory port (read-only use; write controls tied 0)
//   mem_writeEnable,
//   mem_inputData,
//   mem_out
//   out_data, out_valid,  output stream; out_last marks the final word
//   out_ready, out_last
module mem_stream_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int LEN_W      = 16,
  parameter int MEM_WORDS  = 49152,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_writeEnable,
  output logic [DATA_W-1:0] mem_inputData,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] next_addr;
  logic [LEN_W-1:0]  issue_rem;
  logic [LEN_W-1:0]  pop_rem;
  logic              inflight;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic [LEN_W:0]    end_addr;
  logic              range_ok, len_zero, accept;
  logic              credit_ok, issue, push, pop, final_pop;

  assign mem_writeEnable = 1'b0;
  assign mem_inputData   = '0;

  // One extra bit so base_addr+length cannot wrap before the range check.
  assign end_addr = (LEN_W+1)'(base_addr) + (LEN_W+1)'(length);
  assign range_ok = end_addr <= (LEN_W+1)'(MEM_WORDS);
  assign len_zero = (length == '0);
  assign accept   = (state == S_IDLE) && start && !len_zero && range_ok;

  // A read issued last cycle already owns a slot that it fills on this edge.
  assign credit_ok = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight))
                     < (CNT_W+1)'(FIFO_DEPTH);
  assign issue     = (state == S_RUN) && (issue_rem != '0) && credit_ok;
  assign push      = inflight;
  assign pop       = out_valid && out_ready;
  assign final_pop = (state == S_RUN) && pop && (pop_rem == LEN_W'(1));

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (pop_rem == LEN_W'(1));
  assign busy      = (state == S_RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept)    state_nxt = S_RUN;
      S_RUN:  if (final_pop) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr   <= '0;
      issue_rem   <= '0;
      pop_rem     <= '0;
      inflight    <= 1'b0;
      mem_address <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done     <= ((state == S_IDLE) && start && len_zero) || final_pop;
      err      <= (state == S_IDLE) && start && !len_zero && !range_ok;
      inflight <= issue;
      if (accept) begin
        next_addr <= base_addr;
        issue_rem <= length;
        pop_rem   <= length;
      end else begin
        if (issue) begin
          mem_address <= next_addr;
          next_addr   <= next_addr + ADDR_W'(1);
          issue_rem   <= issue_rem - LEN_W'(1);
        end
        if (pop && (state == S_RUN)) pop_rem <= pop_rem - LEN_W'(1);
      end
    end
  end

  // FIFO storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader
//   Directed and randomized transfers against mem_stream_reader. Memory
//   contents come from a salted address function. The expected stream is built
//   straight from the transfer rule: words base..base+len-1 in order, with the
//   last one flagged.
module tb_mem_stream_reader;

  localparam int MEM_WORDS = 49152;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy, done, err;
  logic [15:0] mem_address;
  logic        mem_writeEnable;
  logic [63:0] mem_inputData;
  logic [63:0] mem_out;
  logic [63:0] out_data;
  logic        out_valid, out_ready, out_last;

  int compared   = 0;
  int mismatched = 0;
  int hs_count   = 0;
  logic [31:0] salt;

  logic [63:0] exp_q[$];
  logic        lst_q[$];

  mem_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .err(err),
    .mem_address(mem_address), .mem_writeEnable(mem_writeEnable),
    .mem_inputData(mem_inputData), .mem_out(mem_out), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- memory model ----------------
  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return {a ^ salt[15:0], ~a, salt[31:16] + a, a * 16'd7};
  endfunction

  // mem_address is registered inside the DUT, so a combinational lookup here
  // gives the one-cycle read latency.
  assign mem_out = mem_word(mem_address);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- stream scoreboard ----------------
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() != 0) check("out_last", {63'd0, out_last}, {63'd0, lst_q[0]});
      end else begin
        check("out_last_idle", {63'd0, out_last}, 64'd0);
      end
      if (prev_stall) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        check("hs_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          check("out_data", out_data, exp_q.pop_front());
          void'(lst_q.pop_front());
        end
        hs_count++;
      end
      if (done) check("busy_with_done", {63'd0, busy}, 64'd0);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [15:0] b, input logic [15:0] len);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    length    = len;
    if (len != 0 && (int'(b) + int'(len)) <= MEM_WORDS) begin
      for (int a = int'(b); a < int'(b) + int'(len); a++) begin
        exp_q.push_back(mem_word(16'(a)));
        lst_q.push_back(a == int'(b) + int'(len) - 1);
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: hold ready, 1: toggle ready, 2: random ready
  task automatic wait_done(input int budget, input int mode);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (mode == 1) out_ready = !out_ready;
      else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
    end
    check("done_seen", {63'd0, seen}, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check({tag, "_done"},  {63'd0, done}, 64'd0);
    check({tag, "_err"},   {63'd0, err}, 64'd0);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_last"},  {63'd0, out_last}, 64'd0);
    check({tag, "_addr"},  {48'd0, mem_address}, 64'd0);
    check({tag, "_we"},    {63'd0, mem_writeEnable}, 64'd0);
    check({tag, "_wdata"}, mem_inputData, 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] b, b2, prev_addr, len;
    bit reached;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    salt = $urandom;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // basic: 4 words from 0x10 with ready held high
    out_ready = 1'b1;
    do_start(16'h0010, 16'd4);
    check("basic_busy", {63'd0, busy}, 64'd1);
    check("basic_valid_early", {63'd0, out_valid}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("basic_addr", {48'd0, mem_address}, 64'h10 + 64'(k));
      if (k == 0) check("basic_valid_k0", {63'd0, out_valid}, 64'd0);
      if (k == 1) check("basic_valid_k1", {63'd0, out_valid}, 64'd1);
    end
    @(negedge clk);
    check("basic_last", {63'd0, out_last}, 64'd1);
    check("basic_done_early", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("basic_done", {63'd0, done}, 64'd1);
    check("basic_busy_end", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("basic_done_pulse", {63'd0, done}, 64'd0);
    check("basic_drained", 64'(exp_q.size()), 64'd0);

    // backpressure: 8 words, ready low for 10 cycles
    out_ready = 1'b0;
    b = 16'($urandom_range(0, MEM_WORDS - 8));
    do_start(b, 16'd8);
    repeat (10) @(negedge clk);
    check("bp_addr_stalled", {48'd0, mem_address}, {48'd0, b + 16'd3});
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    check("bp_busy", {63'd0, busy}, 64'd1);
    out_ready = 1'b1;
    wait_done(40, 0);
    @(negedge clk);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // toggling ready, 6 words
    hs_count = 0;
    b = 16'($urandom_range(0, MEM_WORDS - 6));
    do_start(b, 16'd6);
    wait_done(60, 1);
    @(negedge clk);
    check("tog_hs_count", 64'(hs_count), 64'd6);
    check("tog_drained", 64'(exp_q.size()), 64'd0);

    // top-of-memory run is accepted
    out_ready = 1'b1;
    do_start(16'd49148, 16'd4);
    wait_done(30, 0);
    check("top_last_addr", {48'd0, mem_address}, 64'd49151);

    // one word past the end is rejected
    prev_addr = mem_address;
    do_start(16'd49149, 16'd4);
    check("oor_err", {63'd0, err}, 64'd1);
    check("oor_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("oor_err_pulse", {63'd0, err}, 64'd0);
    check("oor_addr", {48'd0, mem_address}, {48'd0, prev_addr});
    check("oor_busy2", {63'd0, busy}, 64'd0);

    // far out of range
    do_start(16'($urandom_range(49153, 65535)), 16'd1);
    check("oor2_err", {63'd0, err}, 64'd1);

    // zero length completes immediately without reads
    do_start(16'($urandom_range(0, MEM_WORDS - 1)), 16'd0);
    check("zero_done", {63'd0, done}, 64'd1);
    check("zero_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("zero_done_pulse", {63'd0, done}, 64'd0);
    check("zero_addr", {48'd0, mem_address}, {48'd0, prev_addr});

    // start while busy is ignored
    hs_count = 0;
    b  = 16'($urandom_range(0, MEM_WORDS - 8));
    b2 = 16'($urandom_range(0, MEM_WORDS - 3));
    do_start(b, 16'd8);
    @(negedge clk);
    start = 1'b1; base_addr = b2; length = 16'd3;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_no_err", {63'd0, err}, 64'd0);
    wait_done(40, 0);
    repeat (10) @(negedge clk);
    check("busy_start_hs", 64'(hs_count), 64'd8);
    check("busy_start_idle", {63'd0, busy}, 64'd0);
    check("busy_start_no_valid", {63'd0, out_valid}, 64'd0);
    check("busy_start_drained", 64'(exp_q.size()), 64'd0);

    // randomized transfers with random backpressure
    for (int t = 0; t < 6; t++) begin
      len = 16'($urandom_range(1, 20));
      b = 16'($urandom_range(0, MEM_WORDS - int'(len)));
      hs_count = 0;
      out_ready = 1'($urandom_range(0, 1));
      do_start(b, len);
      wait_done(400, 2);
      @(negedge clk);
      check("rand_hs_count", 64'(hs_count), {48'd0, len});
      check("rand_drained", 64'(exp_q.size()), 64'd0);
    end

    // reset in the middle of a transfer
    out_ready = 1'b1;
    hs_count = 0;
    do_start(16'($urandom_range(0, MEM_WORDS - 8)), 16'd8);
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(negedge clk);
      if (hs_count >= 3) reached = 1'b1;
    end
    check("mid_reached", {63'd0, reached}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    lst_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hs_count = 0;
    do_start(16'h0020, 16'd2);
    wait_done(20, 0);
    @(negedge clk);
    check("post_rst_hs", 64'(hs_count), 64'd2);
    check("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
